// File: rtl/freq_note_decoder.sv
// Purpose : measure the period of an external tone and report a debounced scale note C4..C5.
// Latency : PERIOD valid 1 CLK after the synchronised rise; NOTE/VALID/NOTE_CHG 2 CLK after it.
// Backpr. : none; FREQ_IN is free-running and every output is a plain registered level/pulse.
//
// Ports:
//   CLK       in   system clock (nominal 100 MHz)
//   RESET_N   in   asynchronous active-low reset, clears all state
//   FREQ_IN   in   tone square wave, asynchronous to CLK
//   NOTE      out  C4=0,D=1,E=2,F=3,G=4,A=5,B=6,C5=7, 4'hF when no note
//   VALID     out  high while NOTE holds a recognised note
//   NOTE_CHG  out  one-cycle pulse whenever NOTE or VALID changes
//   PERIOD    out  last measured period in CLK cycles
module freq_note_decoder #(
  parameter int PERIOD_W   = 20,
  parameter int TIMEOUT    = 800000,
  parameter int TOL        = 5000,
  parameter int STABLE_CNT = 2,
  parameter int P_C4       = 382219,
  parameter int P_D        = 340530,
  parameter int P_E        = 303370,
  parameter int P_F        = 286344,
  parameter int P_G        = 255102,
  parameter int P_A        = 227273,
  parameter int P_B        = 202478,
  parameter int P_C5       = 191113
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                FREQ_IN,
  output logic [3:0]          NOTE,
  output logic                VALID,
  output logic                NOTE_CHG,
  output logic [PERIOD_W-1:0] PERIOD
);

  localparam logic [3:0]          NO_NOTE   = 4'hF;
  localparam int                  MW        = $clog2(STABLE_CNT + 1);
  localparam logic [MW-1:0]       MATCH_MAX = MW'(STABLE_CNT);
  localparam logic [MW-1:0]       MATCH_ONE = MW'(1);
  localparam logic [PERIOD_W-1:0] TO_CNT    = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W:0]   TOL_W     = (PERIOD_W + 1)'(TOL);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t              state;
  logic                sync_1, sync_2, sync_prev;
  logic                rise;
  logic [PERIOD_W-1:0] counter;
  logic [3:0]          cand;
  logic [MW-1:0]       match;
  logic                to_pend;
  logic [3:0]          cls_code;
  logic [PERIOD_W:0]   cnt_x, nom_x, diff_x;

  // Two-flop synchroniser plus an edge register for rise detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= FREQ_IN;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign rise = sync_2 & ~sync_prev;

  function automatic logic [PERIOD_W-1:0] nominal(input int k);
    case (k)
      0:       return PERIOD_W'(P_C4);
      1:       return PERIOD_W'(P_D);
      2:       return PERIOD_W'(P_E);
      3:       return PERIOD_W'(P_F);
      4:       return PERIOD_W'(P_G);
      5:       return PERIOD_W'(P_A);
      6:       return PERIOD_W'(P_B);
      default: return PERIOD_W'(P_C5);
    endcase
  endfunction

  // Window classification of the running count. Scanning downwards lets the
  // lowest code win should overlapping windows ever be configured.
  always_comb begin
    cls_code = NO_NOTE;
    cnt_x    = {1'b0, counter};
    nom_x    = '0;
    diff_x   = '0;
    for (int k = 7; k >= 0; k--) begin
      nom_x  = {1'b0, nominal(k)};
      diff_x = (cnt_x >= nom_x) ? (cnt_x - nom_x) : (nom_x - cnt_x);
      if (diff_x <= TOL_W) cls_code = 4'(k);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      counter  <= '0;
      PERIOD   <= '0;
      cand     <= NO_NOTE;
      match    <= '0;
      to_pend  <= 1'b0;
      NOTE     <= NO_NOTE;
      VALID    <= 1'b0;
      NOTE_CHG <= 1'b0;
    end else begin
      NOTE_CHG <= 1'b0;

      case (state)
        IDLE: begin
          counter <= '0;
          // First edge only starts timing; there is no period to classify yet.
          if (rise) begin
            state   <= MEASURE;
            counter <= PERIOD_W'(1);
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle is checked first so it wins.
          if (rise) begin
            PERIOD  <= counter;
            counter <= PERIOD_W'(1);
            if (cls_code == cand) begin
              if (match != MATCH_MAX) match <= match + MATCH_ONE;
            end else begin
              cand  <= cls_code;
              match <= MATCH_ONE;
            end
          end else if (counter == TO_CNT) begin
            state   <= IDLE;
            counter <= '0;
            cand    <= NO_NOTE;
            match   <= '0;
            to_pend <= 1'b1;
          end else begin
            counter <= counter + PERIOD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Output stage works on the registered candidate, one cycle behind the
      // classification. The !NOTE_CHG term keeps pulses at least one cycle apart.
      if (to_pend) begin
        to_pend <= 1'b0;
        if (VALID) begin
          NOTE     <= NO_NOTE;
          VALID    <= 1'b0;
          NOTE_CHG <= 1'b1;
        end
      end else if (match == MATCH_MAX && !NOTE_CHG &&
                   (cand != NOTE || (cand != NO_NOTE) != VALID)) begin
        NOTE     <= cand;
        VALID    <= (cand != NO_NOTE);
        NOTE_CHG <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_note_decoder.sv
// Purpose : directed bench for freq_note_decoder with a scoreboard of expected NOTE changes.
// Latency : periods scaled down by ~100x so the whole run stays short.
// Backpr. : n/a.
module tb_freq_note_decoder;

  localparam int PW    = 20;
  localparam int TO    = 4000;
  localparam int TOLB  = 50;
  localparam int PC4   = 3822;
  localparam int PD    = 3405;
  localparam int PE    = 3034;
  localparam int PF    = 2863;
  localparam int PG    = 2551;
  localparam int PA    = 2273;
  localparam int PB    = 2025;
  localparam int PC5   = 1911;
  localparam int PGAP  = 2150;   // between the A and B windows

  logic          CLK;
  logic          RESET_N;
  logic          FREQ_IN;
  logic [3:0]    NOTE;
  logic          VALID;
  logic          NOTE_CHG;
  logic [PW-1:0] PERIOD;

  typedef struct {
    logic [3:0] note;
    logic       valid;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  logic prev_chg = 1'b0;

  freq_note_decoder #(
    .PERIOD_W(PW), .TIMEOUT(TO), .TOL(TOLB), .STABLE_CNT(2),
    .P_C4(PC4), .P_D(PD), .P_E(PE), .P_F(PF),
    .P_G(PG), .P_A(PA), .P_B(PB), .P_C5(PC5)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FREQ_IN(FREQ_IN),
    .NOTE(NOTE), .VALID(VALID), .NOTE_CHG(NOTE_CHG), .PERIOD(PERIOD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [3:0] n, input logic v);
    ev_t e;
    e.note  = n;
    e.valid = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // n rising edges spaced exactly p cycles apart; each is followed by a full period.
  task automatic tone(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      FREQ_IN = 1'b1;
      wait_cyc(p / 2);
      FREQ_IN = 1'b0;
      wait_cyc(p - p / 2);
    end
  endtask

  task automatic chk_period(input string tag, input int p);
    chk(tag, 32'((int'(PERIOD) >= p - 1) && (int'(PERIOD) <= p + 1)), 32'd1);
  endtask

  // Scoreboard: every NOTE_CHG pulse must match the next expected event.
  always @(negedge CLK) begin
    if (RESET_N && NOTE_CHG) begin
      chk("chg_gap", 32'(prev_chg), 32'd0);
      chk("chg_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        chk("chg_note", 32'(NOTE), 32'(e.note));
        chk("chg_valid", 32'(VALID), 32'(e.valid));
      end
    end
    prev_chg = RESET_N ? NOTE_CHG : 1'b0;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    FREQ_IN = 1'b0;

    // 1: reset held with the input toggling
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      FREQ_IN = ~FREQ_IN;
    end
    chk("rst_note", 32'(NOTE), 32'hF);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_period", 32'(PERIOD), 32'd0);
    chk("rst_chg", 32'(NOTE_CHG), 32'd0);
    FREQ_IN = 1'b0;
    wait_cyc(3);
    RESET_N = 1'b1;
    wait_cyc(5);
    chk("post_rst_note", 32'(NOTE), 32'hF);
    chk("post_rst_valid", 32'(VALID), 32'd0);

    // 2: A tone, 4 periods -> NOTE=5 after the 3rd rise
    push_exp(4'd5, 1'b1);
    tone(PA, 4);
    chk_period("a_period", PA);
    chk("a_note", 32'(NOTE), 32'd5);
    chk("a_valid", 32'(VALID), 32'd1);
    chk("a_pending", 32'(exp_q.size()), 32'd0);

    // 3: switch to C4; the first C4 rise still closes an A period
    push_exp(4'd0, 1'b1);
    tone(PC4, 3);
    chk_period("c4_period", PC4);
    chk("c4_note", 32'(NOTE), 32'd0);
    chk("c4_pending", 32'(exp_q.size()), 32'd0);

    // 4: hold high after a last rise -> timeout drops the note
    push_exp(4'hF, 1'b0);
    FREQ_IN = 1'b1;
    wait_cyc(TO / 2);
    chk("to_early_valid", 32'(VALID), 32'd1);
    wait_cyc(TO / 2 + 20);
    chk("to_note", 32'(NOTE), 32'hF);
    chk("to_valid", 32'(VALID), 32'd0);
    chk_period("to_period_kept", PC4);
    chk("to_pending", 32'(exp_q.size()), 32'd0);
    FREQ_IN = 1'b0;
    wait_cyc(20);

    // 5: G stable, then an unclassifiable period -> NOTE=F from G
    push_exp(4'd4, 1'b1);
    tone(PG, 4);
    chk("g_note", 32'(NOTE), 32'd4);
    chk("g_pending", 32'(exp_q.size()), 32'd0);
    push_exp(4'hF, 1'b0);
    tone(PGAP, 4);
    chk_period("gap_period", PGAP);
    chk("gap_note", 32'(NOTE), 32'hF);
    chk("gap_valid", 32'(VALID), 32'd0);
    chk("gap_pending", 32'(exp_q.size()), 32'd0);

    // 6: G stable, one C5 period inserted, G resumes -> no change
    push_exp(4'd4, 1'b1);
    tone(PG, 3);
    chk("g2_note", 32'(NOTE), 32'd4);
    chk("g2_pending", 32'(exp_q.size()), 32'd0);
    tone(PC5, 1);
    tone(PG, 3);
    chk_period("odd_period", PG);
    chk("odd_note", 32'(NOTE), 32'd4);
    chk("odd_valid", 32'(VALID), 32'd1);
    chk("odd_pending", 32'(exp_q.size()), 32'd0);

    // Mid-period asynchronous reset, sampled before the next clock edge
    FREQ_IN = 1'b1;
    wait_cyc(1000);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_note", 32'(NOTE), 32'hF);
    chk("arst_valid", 32'(VALID), 32'd0);
    chk("arst_period", 32'(PERIOD), 32'd0);
    chk("arst_chg", 32'(NOTE_CHG), 32'd0);
    wait_cyc(5);
    chk("arst_hold_note", 32'(NOTE), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
